// File: rtl/alu_acc_unit.sv
// alu_acc_unit: execution datapath stage downstream of the control sequencer.
//
// Holds the accumulator (A), the B register, a combinational ALU, the status
// flags, the output (display) register and a sticky control-error flag. Drives
// the W bus with the ALU result or with A when the sequencer asks for it.
//
// Build option:
//   ALU_PARITY_EN  when defined, adds an even-parity flag register (flag_p)
//                  that updates alongside the other flags. When undefined,
//                  flag_p is tied low and no parity logic exists.
//
// Ports:
//   clk             rising-edge clock
//   clr             asynchronous active-high reset
//   w_bus_in        W bus value (load source for A and B)
//   low_ld_acc      active-low accumulator load
//   acc_out_en      drive A onto the bus
//   low_ld_b_reg    active-low B load
//   sub_add         1 = subtract on the default add/sub path
//   xor_ratna .. sta_imm  ALU op selects (priority: xor, and, or, cmp, lda, sta)
//   subadd_out_en   drive ALU result onto the bus / select ALU as A source
//   low_ld_out_reg  active-low output register load
//   w_bus_out       bus drive value (0 when not driving)
//   w_bus_drive     1 when this block drives the bus
//   out_reg         output register
//   acc             accumulator contents
//   flag_c/z/n/v    carry (1 = no borrow on subtract), zero, negative, overflow
//   flag_p          even parity of the last flag-updating result
//   op_err          sticky: multiple op selects or bus conflict seen
module alu_acc_unit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] w_bus_in,
  input  logic             low_ld_acc,
  input  logic             acc_out_en,
  input  logic             low_ld_b_reg,
  input  logic             sub_add,
  input  logic             xor_ratna,
  input  logic             and_ratna,
  input  logic             or_ratna,
  input  logic             cmp_ratna,
  input  logic             lda_imm,
  input  logic             sta_imm,
  input  logic             subadd_out_en,
  input  logic             low_ld_out_reg,
  output logic [WIDTH-1:0] w_bus_out,
  output logic             w_bus_drive,
  output logic [WIDTH-1:0] out_reg,
  output logic [WIDTH-1:0] acc,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v,
  output logic             flag_p,
  output logic             op_err
);

  typedef enum logic [2:0] {
    OpXor,
    OpAnd,
    OpOr,
    OpCmp,
    OpLda,
    OpSta,
    OpAdd,
    OpSub
  } op_e;

  // State
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             flag_c_q, flag_c_d;
  logic             flag_z_q, flag_z_d;
  logic             flag_n_q, flag_n_d;
  logic             flag_v_q, flag_v_d;
  logic             op_err_q, op_err_d;

  // ALU
  op_e              op;
  logic [5:0]       sel_vec;
  logic             multi_sel;
  logic             is_arith;
  logic             is_sub;
  logic [WIDTH-1:0] b_opnd;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic             flag_upd;

  // Op decode, in fixed priority order.
  always_comb begin
    if (xor_ratna) begin
      op = OpXor;
    end else if (and_ratna) begin
      op = OpAnd;
    end else if (or_ratna) begin
      op = OpOr;
    end else if (cmp_ratna) begin
      op = OpCmp;
    end else if (lda_imm) begin
      op = OpLda;
    end else if (sta_imm) begin
      op = OpSta;
    end else if (sub_add) begin
      op = OpSub;
    end else begin
      op = OpAdd;
    end
  end

  assign sel_vec   = {xor_ratna, and_ratna, or_ratna, cmp_ratna, lda_imm, sta_imm};
  // More than one bit set iff clearing the lowest set bit leaves something.
  assign multi_sel = |(sel_vec & (sel_vec - 6'd1));

  assign is_sub   = (op == OpSub) || (op == OpCmp);
  assign is_arith = is_sub || (op == OpAdd);

  // Subtraction shares the adder as A + ~B + 1.
  assign b_opnd = is_sub ? ~b_q : b_q;
  assign sum    = {1'b0, acc_q} + {1'b0, b_opnd} + {{WIDTH{1'b0}}, is_sub};

  always_comb begin
    alu_res = sum[WIDTH-1:0];
    unique case (op)
      OpXor:   alu_res = acc_q ^ b_q;
      OpAnd:   alu_res = acc_q & b_q;
      OpOr:    alu_res = acc_q | b_q;
      OpLda:   alu_res = b_q;
      OpSta:   alu_res = acc_q;
      default: alu_res = sum[WIDTH-1:0];
    endcase
  end

  // Signed overflow: operands of equal sign producing a result of the other sign.
  assign alu_c = is_arith & sum[WIDTH];
  assign alu_v = is_arith & (acc_q[WIDTH-1] == b_opnd[WIDTH-1]) &
                 (sum[WIDTH-1] != acc_q[WIDTH-1]);

  assign flag_upd = ~low_ld_acc & subadd_out_en;

  // Next-state logic. All registers read pre-edge values, so a B load and an
  // A-from-ALU load on the same edge use old B, and out_reg captures old A.
  always_comb begin
    acc_d    = acc_q;
    b_d      = b_q;
    out_d    = out_q;
    flag_c_d = flag_c_q;
    flag_z_d = flag_z_q;
    flag_n_d = flag_n_q;
    flag_v_d = flag_v_q;
    op_err_d = op_err_q;

    if (!low_ld_b_reg) begin
      b_d = w_bus_in;
    end

    if (!low_ld_out_reg) begin
      out_d = acc_q;
    end

    if (!low_ld_acc) begin
      if (subadd_out_en) begin
        // Compare only sets flags; A keeps its value.
        if (op != OpCmp) begin
          acc_d = alu_res;
        end
      end else begin
        acc_d = w_bus_in;
      end
    end

    if (flag_upd) begin
      flag_c_d = alu_c;
      flag_z_d = (alu_res == '0);
      flag_n_d = alu_res[WIDTH-1];
      flag_v_d = alu_v;
    end

    if (subadd_out_en && (multi_sel || acc_out_en)) begin
      op_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      acc_q    <= '0;
      b_q      <= '0;
      out_q    <= '0;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
      flag_v_q <= 1'b0;
      op_err_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      b_q      <= b_d;
      out_q    <= out_d;
      flag_c_q <= flag_c_d;
      flag_z_q <= flag_z_d;
      flag_n_q <= flag_n_d;
      flag_v_q <= flag_v_d;
      op_err_q <= op_err_d;
    end
  end

`ifdef ALU_PARITY_EN
  logic flag_p_q, flag_p_d;

  always_comb begin
    flag_p_d = flag_p_q;
    if (flag_upd) begin
      flag_p_d = ~^alu_res;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      flag_p_q <= 1'b0;
    end else begin
      flag_p_q <= flag_p_d;
    end
  end

  assign flag_p = flag_p_q;
`else
  assign flag_p = 1'b0;
`endif

  // Bus drive: ALU result wins over A; nothing is driven while in reset.
  always_comb begin
    w_bus_out   = '0;
    w_bus_drive = 1'b0;
    if (!clr) begin
      if (subadd_out_en) begin
        w_bus_out   = alu_res;
        w_bus_drive = 1'b1;
      end else if (acc_out_en) begin
        w_bus_out   = acc_q;
        w_bus_drive = 1'b1;
      end
    end
  end

  assign acc     = acc_q;
  assign out_reg = out_q;
  assign flag_c  = flag_c_q;
  assign flag_z  = flag_z_q;
  assign flag_n  = flag_n_q;
  assign flag_v  = flag_v_q;
  assign op_err  = op_err_q;

endmodule

// File: tb/tb_alu_acc_unit.sv
// Self-checking bench for alu_acc_unit: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model. Build with +define+ALU_PARITY_EN to cover flag_p.
module tb_alu_acc_unit;
  localparam int W = 8;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         clr = 1'b1;
  logic [W-1:0] w_bus_in;
  logic         low_ld_acc, acc_out_en, low_ld_b_reg, sub_add;
  logic         xor_ratna, and_ratna, or_ratna, cmp_ratna, lda_imm, sta_imm;
  logic         subadd_out_en, low_ld_out_reg;
  logic [W-1:0] w_bus_out, out_reg, acc;
  logic         w_bus_drive, flag_c, flag_z, flag_n, flag_v, flag_p, op_err;

  int total = 0;
  int bad   = 0;

  alu_acc_unit #(.WIDTH(W)) dut (
    .clk           (clk),
    .clr           (clr),
    .w_bus_in      (w_bus_in),
    .low_ld_acc    (low_ld_acc),
    .acc_out_en    (acc_out_en),
    .low_ld_b_reg  (low_ld_b_reg),
    .sub_add       (sub_add),
    .xor_ratna     (xor_ratna),
    .and_ratna     (and_ratna),
    .or_ratna      (or_ratna),
    .cmp_ratna     (cmp_ratna),
    .lda_imm       (lda_imm),
    .sta_imm       (sta_imm),
    .subadd_out_en (subadd_out_en),
    .low_ld_out_reg(low_ld_out_reg),
    .w_bus_out     (w_bus_out),
    .w_bus_drive   (w_bus_drive),
    .out_reg       (out_reg),
    .acc           (acc),
    .flag_c        (flag_c),
    .flag_z        (flag_z),
    .flag_n        (flag_n),
    .flag_v        (flag_v),
    .flag_p        (flag_p),
    .op_err        (op_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_a = 0, m_b = 0, m_out = 0;
  bit m_c = 0, m_z = 0, m_n = 0, m_v = 0, m_p = 0, m_err = 0;

  function automatic int sgn(input int x);
    return (x >= M / 2) ? x - M : x;
  endfunction

  function automatic bit even_par(input int x);
    int n = 0;
    for (int i = 0; i < W; i++) n += (x >> i) & 1;
    return (n % 2) == 0;
  endfunction

  // ops = {xor, and, or, cmp, lda, sta, sub_add}
  function automatic void model_alu(input int a, input int b, input logic [6:0] ops,
                                    output int res, output bit c, output bit v);
    int s;
    res = 0;
    c   = 1'b0;
    v   = 1'b0;
    if (ops[6]) res = a ^ b;
    else if (ops[5]) res = a & b;
    else if (ops[4]) res = a | b;
    else if (ops[3] || (!ops[2] && !ops[1] && ops[0])) begin
      res = (a - b + M) % M;
      c   = (a >= b);
      s   = sgn(a) - sgn(b);
      v   = (s > M / 2 - 1) || (s < -(M / 2));
    end
    else if (ops[2]) res = b;
    else if (ops[1]) res = a;
    else begin
      res = (a + b) % M;
      c   = (a + b) >= M;
      s   = sgn(a) + sgn(b);
      v   = (s > M / 2 - 1) || (s < -(M / 2));
    end
  endfunction

  int   exp_res;
  bit   exp_c, exp_v;
  bit   eff_cmp;
  int   nsel;

  always_comb begin
    exp_res = 0;
    exp_c   = 1'b0;
    exp_v   = 1'b0;
    model_alu(m_a, m_b, {xor_ratna, and_ratna, or_ratna, cmp_ratna, lda_imm, sta_imm, sub_add},
              exp_res, exp_c, exp_v);
    eff_cmp = cmp_ratna && !xor_ratna && !and_ratna && !or_ratna;
    nsel = int'(xor_ratna) + int'(and_ratna) + int'(or_ratna) + int'(cmp_ratna) +
           int'(lda_imm) + int'(sta_imm);
  end

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      m_a <= 0; m_b <= 0; m_out <= 0;
      m_c <= 0; m_z <= 0; m_n <= 0; m_v <= 0; m_p <= 0; m_err <= 0;
    end else begin
      if (!low_ld_b_reg) m_b <= int'(w_bus_in);
      if (!low_ld_out_reg) m_out <= m_a;
      if (!low_ld_acc) begin
        if (subadd_out_en) begin
          if (!eff_cmp) m_a <= exp_res;
          m_c <= exp_c;
          m_v <= exp_v;
          m_z <= (exp_res == 0);
          m_n <= (exp_res >= M / 2);
`ifdef ALU_PARITY_EN
          m_p <= even_par(exp_res);
`endif
        end else begin
          m_a <= int'(w_bus_in);
        end
      end
      if (subadd_out_en && (nsel > 1 || acc_out_en)) m_err <= 1'b1;
    end
  end

  // Compare every cycle on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!clr) begin
      chk("acc", int'(acc), m_a);
      chk("out_reg", int'(out_reg), m_out);
      chk("flag_c", int'(flag_c), int'(m_c));
      chk("flag_z", int'(flag_z), int'(m_z));
      chk("flag_n", int'(flag_n), int'(m_n));
      chk("flag_v", int'(flag_v), int'(m_v));
      chk("flag_p", int'(flag_p), int'(m_p));
      chk("op_err", int'(op_err), int'(m_err));
      chk("w_bus_drive", int'(w_bus_drive), int'(subadd_out_en || acc_out_en));
      chk("w_bus_out", int'(w_bus_out),
          subadd_out_en ? exp_res : (acc_out_en ? m_a : 0));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    w_bus_in = '0;
    low_ld_acc = 1'b1; acc_out_en = 1'b0; low_ld_b_reg = 1'b1; sub_add = 1'b0;
    xor_ratna = 1'b0; and_ratna = 1'b0; or_ratna = 1'b0; cmp_ratna = 1'b0;
    lda_imm = 1'b0; sta_imm = 1'b0; subadd_out_en = 1'b0; low_ld_out_reg = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lda(input logic [W-1:0] v);
    idle(); low_ld_acc = 1'b0; w_bus_in = v; tick(); idle();
  endtask

  task automatic ldb(input logic [W-1:0] v);
    idle(); low_ld_b_reg = 1'b0; w_bus_in = v; tick(); idle();
  endtask

  // Mid-cycle asynchronous reset pulse, checked before any clock edge.
  task automatic clr_pulse();
    #1 clr = 1'b1;
    #1;
    chk("clr_acc", int'(acc), 0);
    chk("clr_out", int'(out_reg), 0);
    chk("clr_flags", int'({flag_c, flag_z, flag_n, flag_v, flag_p}), 0);
    chk("clr_err", int'(op_err), 0);
    chk("clr_drive", int'(w_bus_drive), 0);
    clr = 1'b0;
  endtask

  initial begin
    logic [5:0] sel;
    int         i, j;
    idle();
    #11;
    chk("rst_acc", int'(acc), 0);
    chk("rst_err", int'(op_err), 0);
    clr = 1'b0;
    tick();

    // Populate state, then clear it asynchronously mid-cycle.
    ldb(8'h33);
    lda(8'h55);
    acc_out_en = 1'b1; subadd_out_en = 1'b1; xor_ratna = 1'b1; low_ld_out_reg = 1'b0;
    tick(); idle();
    chk("pre_clr_out", int'(out_reg), 'h55);
    chk("pre_clr_err", int'(op_err), 1);
    clr_pulse();
    subadd_out_en = 1'b1; lda_imm = 1'b1;
    #1;
    chk("clr_b_zero", int'(w_bus_out), 0);
    idle();
    tick();

    // LDA 7, B <- 5, add.
    lda(8'h07);
    ldb(8'h05);
    low_ld_acc = 1'b0; subadd_out_en = 1'b1;
    #1;
    chk("add_bus", int'(w_bus_out), 'h0C);
    chk("add_drive", int'(w_bus_drive), 1);
    tick(); idle();
    chk("add_acc", int'(acc), 'h0C);
    chk("add_model", m_a, 'h0C);
    chk("add_flags", int'({flag_c, flag_z, flag_n, flag_v}), 0);

    // 3 - 5, then 0x80 - 1.
    lda(8'h03);
    ldb(8'h05);
    low_ld_acc = 1'b0; subadd_out_en = 1'b1; sub_add = 1'b1;
    tick(); idle();
    chk("sub_acc", int'(acc), 'hFE);
    chk("sub_cn", int'({flag_c, flag_n}), 'b01);
    lda(8'h80);
    ldb(8'h01);
    low_ld_acc = 1'b0; subadd_out_en = 1'b1; sub_add = 1'b1;
    tick(); idle();
    chk("subv_acc", int'(acc), 'h7F);
    chk("subv_v", int'(flag_v), 1);
    chk("subv_model_v", int'(m_v), 1);

    // Compare equal values: A holds, z=1, c=1.
    lda(8'h42);
    ldb(8'h42);
    low_ld_acc = 1'b0; subadd_out_en = 1'b1; cmp_ratna = 1'b1;
    tick(); idle();
    chk("cmp_acc", int'(acc), 'h42);
    chk("cmp_zc", int'({flag_z, flag_c}), 'b11);

    // Bus conflict: ALU result wins, op_err sticks until clr.
    acc_out_en = 1'b1; subadd_out_en = 1'b1;
    #1;
    chk("conf_bus", int'(w_bus_out), 'h84);
    tick(); idle();
    chk("conf_err", int'(op_err), 1);
    tick(); tick();
    chk("conf_err_sticky", int'(op_err), 1);
    clr_pulse();
    tick();

    // OR into 0xFF, parity, then out_reg load.
    lda(8'h0F);
    ldb(8'hF0);
    low_ld_acc = 1'b0; subadd_out_en = 1'b1; or_ratna = 1'b1;
    tick(); idle();
    chk("or_acc", int'(acc), 'hFF);
`ifdef ALU_PARITY_EN
    chk("or_parity", int'(flag_p), 1);
`else
    chk("or_parity_off", int'(flag_p), 0);
`endif
    low_ld_out_reg = 1'b0;
    tick(); idle();
    chk("out_ff", int'(out_reg), 'hFF);

    // Wrap-around.
    lda(8'hFF);
    ldb(8'h01);
    low_ld_acc = 1'b0; subadd_out_en = 1'b1;
    tick(); idle();
    chk("wrap_acc", int'(acc), 0);
    chk("wrap_cz", int'({flag_c, flag_z}), 'b11);

    // Same-edge B load / A-from-ALU / out_reg load all see old values.
    lda(8'h10);
    ldb(8'h01);
    low_ld_acc = 1'b0; subadd_out_en = 1'b1; low_ld_b_reg = 1'b0; w_bus_in = 8'h20;
    low_ld_out_reg = 1'b0;
    tick(); idle();
    chk("same_edge_acc", int'(acc), 'h11);
    chk("same_edge_out", int'(out_reg), 'h10);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      w_bus_in       = W'($urandom);
      low_ld_acc     = 1'($urandom_range(0, 1));
      low_ld_b_reg   = 1'($urandom_range(0, 1));
      low_ld_out_reg = 1'($urandom_range(0, 1));
      sub_add        = 1'($urandom_range(0, 1));
      subadd_out_en  = 1'($urandom_range(0, 1));
      acc_out_en     = ($urandom_range(0, 3) == 0);
      sel = '0;
      i = $urandom_range(0, 9);
      if (i < 6) begin
        sel[i] = 1'b1;
      end else if (i == 6) begin
        i = $urandom_range(0, 5);
        j = (i + 1 + $urandom_range(0, 4)) % 6;
        sel[i] = 1'b1;
        sel[j] = 1'b1;
      end
      // Keep cmp only where its A-hold meaning is unambiguous.
      if (sel[2] && (sel[5:3] != '0 || !subadd_out_en)) sel[2] = 1'b0;
      {xor_ratna, and_ratna, or_ratna, cmp_ratna, lda_imm, sta_imm} = sel;
      if ($urandom_range(0, 80) == 0) clr_pulse();
      tick();
    end

    idle();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_acc_unit.md
Name: alu_acc_unit

Overview:
- Execution datapath stage directly downstream of control_sequencer. Consumes its ALU, accumulator, B-register and output-register controls.
- Holds the accumulator (A), B register, ALU, status flags and output register.
- Drives the W bus when the sequencer enables the accumulator or ALU result.

Parameters:
- WIDTH, 8, data path width in bits for A, B, ALU, bus and output register.

Ports:
- clk  input  1  rising-edge clock
- clr  input  1  asynchronous active-high reset
- w_bus_in  input  WIDTH  W bus value (memory data for B/A loads)
- low_ld_acc  input  1  active-low accumulator load
- acc_out_en  input  1  drive A onto bus
- low_ld_b_reg  input  1  active-low B load
- sub_add  input  1  1 = subtract
- xor_ratna, and_ratna, or_ratna, cmp_ratna, lda_imm, sta_imm  input  1 each  ALU op selects
- subadd_out_en  input  1  drive ALU result onto bus / select ALU as A source
- low_ld_out_reg  input  1  active-low output register load
- w_bus_out  output  WIDTH  bus drive value
- w_bus_drive  output  1  1 when this block drives the bus
- out_reg  output  WIDTH  output register (display)
- acc  output  WIDTH  accumulator contents
- flag_c, flag_z, flag_n, flag_v  output  1 each  carry, zero, negative, overflow
- flag_p  output  1  even parity (see Optional Feature)
- op_err  output  1  sticky: illegal op-select combination or bus conflict

Behaviour:
- Reset (clr=1, async): A, B, out_reg = 0; all flags = 0; op_err = 0; w_bus_drive = 0; w_bus_out = 0. Reset overrides all loads, including mid-instruction.
- ALU is combinational on A and B. Op selection in priority order:
  - xor: A^B
  - and: A&B
  - or: A|B
  - cmp: A−B
  - lda_imm: B
  - sta_imm: A
  - otherwise: A+B, or A−B when sub_add=1
- Subtraction is A + ~B + 1. flag_c is the carry out, so 1 means no borrow.
- flag_v is two's-complement overflow for add/sub/cmp and 0 for all other ops.
- Each flag register updates only on an edge where ~low_ld_acc & subadd_out_en:
  - flag_z = (result == 0)
  - flag_n = result MSB
  - flag_c = carry for add/sub/cmp, else 0
- Latency: one clock from control assertion to A/B/out_reg/flags update.
- B register: loads w_bus_in on an edge with low_ld_b_reg=0.
- A register, on an edge with low_ld_acc=0:
  - subadd_out_en=1 and not cmp: load ALU result
  - cmp_ratna=1: A holds; flags still update
  - subadd_out_en=0: load w_bus_in (LDA path)
- out_reg: loads A (pre-edge value) on an edge with low_ld_out_reg=0.
- Bus drive:
  - subadd_out_en=1: w_bus_out = ALU result, w_bus_drive = 1
  - else acc_out_en=1: w_bus_out = A, w_bus_drive = 1
  - else: w_bus_drive = 0, w_bus_out = 0
- Simultaneous events:
  - B load and A-from-ALU load on the same edge: the ALU uses the old B.
  - A load and out_reg load on the same edge: out_reg gets the old A.
- op_err is set on any edge where:
  - more than one of xor/and/or/cmp/lda_imm/sta_imm is high while subadd_out_en=1, or
  - acc_out_en and subadd_out_en are both high.
  It is cleared only by clr. Priority resolution still applies.
- Wrap-around: results are truncated to WIDTH; 0xFF+0x01 gives 0x00 with flag_c=1.

Optional Feature:
- Macro ALU_PARITY_EN.
- Defined: flag_p register, updated under the same condition as the other flags, equal to ~^result (1 = even number of ones). Reset value 0.
- Undefined: flag_p is tied 0 and no parity logic is synthesized. All other behaviour is identical.

Test Plan:
- Assert clr mid-cycle with A=0x55 → A, B, out_reg, flags and op_err all 0 immediately, without waiting for a clock edge.
- LDA 0x07 (bus=0x07, low_ld_acc=0), then B←0x05, then add with subadd_out_en=1 → A=0x0C, c=0, z=0, n=0, v=0, w_bus_out=0x0C during the add cycle.
- A=0x03, B=0x05, sub_add=1 → A=0xFE, c=0, n=1; next, A=0x80, B=0x01, sub → A=0x7F, v=1.
- A=0x42, B=0x42, cmp_ratna=1 → A stays 0x42, z=1, c=1.
- acc_out_en=1 and subadd_out_en=1 together → w_bus_out = ALU result and op_err=1, staying 1 until clr.
- Parity build, A=0x0F, B=0xF0, or_ratna → A=0xFF, flag_p=1; then low_ld_out_reg=0 → out_reg=0xFF one cycle later.
